// File: rtl/mimo_pkg.sv
// Shared types, widths and saturating fixed-point helpers for the 2x2 channel-matrix inverter.
package mimo_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned FRAC   = 11;
  localparam int unsigned NUM_W  = 3 * FRAC + 1;
  localparam int unsigned WIDE_W = 2 * DATA_W + 1;
  localparam int unsigned CNT_W  = $clog2(NUM_W + 1);

  typedef logic signed [DATA_W-1:0] samp_t;
  typedef logic signed [WIDE_W-1:0] wide_t;
  typedef logic        [WIDE_W-1:0] norm_t;

  typedef struct packed {
    samp_t re;
    samp_t im;
  } cplx_t;

  typedef enum logic [2:0] {StIdle, StDet, StNorm, StDiv, StScale, StAdj} state_e;

  localparam wide_t SAT_MAX = {{(WIDE_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam wide_t SAT_MIN = {{(WIDE_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};
  localparam logic [NUM_W-1:0] RECIP_MAX = NUM_W'(SAT_MAX);

  function automatic wide_t widen(samp_t x);
    return wide_t'(x);
  endfunction

  function automatic samp_t sat(wide_t x);
    if (x > SAT_MAX) return samp_t'(SAT_MAX);
    if (x < SAT_MIN) return samp_t'(SAT_MIN);
    return samp_t'(x);
  endfunction

  function automatic samp_t sat_add(samp_t a, samp_t b);
    return sat(widen(a) + widen(b));
  endfunction

  function automatic samp_t sat_sub(samp_t a, samp_t b);
    return sat(widen(a) - widen(b));
  endfunction

  function automatic samp_t sat_neg(samp_t a);
    return sat(-widen(a));
  endfunction

  // Reciprocal is non-negative, so only the upper bound needs clamping.
  function automatic logic [DATA_W-1:0] clamp_recip(logic [NUM_W-1:0] q);
    if (q > RECIP_MAX) return DATA_W'(RECIP_MAX);
    return DATA_W'(q);
  endfunction

  function automatic cplx_t cmul(cplx_t a, cplx_t b);
    cplx_t res;
    wide_t re_w;
    wide_t im_w;
    re_w = (widen(a.re) * widen(b.re) - widen(a.im) * widen(b.im)) >>> FRAC;
    im_w = (widen(a.re) * widen(b.im) + widen(a.im) * widen(b.re)) >>> FRAC;
    res.re = sat(re_w);
    res.im = sat(im_w);
    return res;
  endfunction

endpackage

// File: rtl/mimo_hinv_2x2_if.sv
// Request/result bundle between the channel estimator, the inverter and the equalizer.
interface mimo_hinv_2x2_if;
  import mimo_pkg::*;

  logic  in_valid;
  logic  in_ready;
  samp_t h00_re, h00_im, h01_re, h01_im, h10_re, h10_im, h11_re, h11_im;
  logic  out_valid;
  logic  singular;
  samp_t i00_re, i00_im, i01_re, i01_im, i10_re, i10_im, i11_re, i11_im;

  modport master (
    output in_valid, h00_re, h00_im, h01_re, h01_im, h10_re, h10_im, h11_re, h11_im,
    input  in_ready, out_valid, singular,
    input  i00_re, i00_im, i01_re, i01_im, i10_re, i10_im, i11_re, i11_im
  );

  modport slave (
    input  in_valid, h00_re, h00_im, h01_re, h01_im, h10_re, h10_im, h11_re, h11_im,
    output in_ready, out_valid, singular,
    output i00_re, i00_im, i01_re, i01_im, i10_re, i10_im, i11_re, i11_im
  );
endinterface

// File: rtl/mimo_recip_div.sv
// Bit-serial restoring divider: recip_o = min(floor(2^(3*FRAC) / den), 2^(DATA_W-1)-1).
module mimo_recip_div
  import mimo_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  norm_t             den_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] recip_o
);

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [NUM_W-1:0] quo_q, quo_d;
  norm_t            den_q, den_d;
  norm_t            rem_q, rem_d;
  logic [WIDE_W:0]  rem_sh;
  logic [WIDE_W:0]  rem_sub;
  logic             q_bit;

  always_comb begin
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    quo_d   = quo_q;
    den_d   = den_q;
    rem_d   = rem_q;
    rem_sh  = {rem_q, num_q[NUM_W-1]};
    rem_sub = rem_sh - {1'b0, den_q};
    q_bit   = (rem_sh >= {1'b0, den_q});

    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = CNT_W'(NUM_W);
      num_d  = NUM_W'(1) << (3 * FRAC);
      quo_d  = '0;
      den_d  = den_i;
      rem_d  = '0;
    end else if (busy_q) begin
      // After a restore the partial remainder is below den, so WIDE_W bits hold it.
      rem_d = q_bit ? rem_sub[WIDE_W-1:0] : rem_sh[WIDE_W-1:0];
      quo_d = {quo_q[NUM_W-2:0], q_bit};
      num_d = num_q << 1;
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      num_q  <= '0;
      quo_q  <= '0;
      den_q  <= '0;
      rem_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      num_q  <= num_d;
      quo_q  <= quo_d;
      den_q  <= den_d;
      rem_q  <= rem_d;
    end
  end

  assign busy_o  = busy_q;
  // High during the final iteration; recip_o is valid from the following cycle.
  assign done_o  = busy_q && (cnt_q == CNT_W'(1));
  assign recip_o = clamp_recip(quo_q);

endmodule

// File: rtl/mimo_hinv_2x2.sv
// 2x2 complex matrix inverter: H_inv = adj(H) * conj(det) / |det|^2, results held until next update.
module mimo_hinv_2x2
  import mimo_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  mimo_hinv_2x2_if.slave  hinv
);

  state_e state_q, state_d;
  cplx_t  h00_q, h00_d, h01_q, h01_d, h10_q, h10_d, h11_q, h11_d;
  cplx_t  det_q, det_d;
  cplx_t  s_q, s_d;
  logic   sing_q, sing_d;
  logic   out_valid_q, out_valid_d;
  logic   singular_q, singular_d;
  cplx_t  i00_q, i00_d, i01_q, i01_d, i10_q, i10_d, i11_q, i11_d;

  logic              div_start;
  logic              div_busy;
  logic              div_done;
  logic [DATA_W-1:0] div_recip;
  norm_t             norm;
  cplx_t             p_diag, p_anti, c01, c10;
  wide_t             recip_w;

  mimo_recip_div u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (div_start),
    .den_i   (norm),
    .busy_o  (div_busy),
    .done_o  (div_done),
    .recip_o (div_recip)
  );

  always_comb begin
    state_d     = state_q;
    h00_d       = h00_q;
    h01_d       = h01_q;
    h10_d       = h10_q;
    h11_d       = h11_q;
    det_d       = det_q;
    s_d         = s_q;
    sing_d      = sing_q;
    out_valid_d = 1'b0;
    singular_d  = singular_q;
    i00_d       = i00_q;
    i01_d       = i01_q;
    i10_d       = i10_q;
    i11_d       = i11_q;
    div_start   = 1'b0;
    p_diag      = cmul(h00_q, h11_q);
    p_anti      = cmul(h01_q, h10_q);
    norm        = $unsigned(widen(det_q.re) * widen(det_q.re) +
                            widen(det_q.im) * widen(det_q.im));
    recip_w     = wide_t'(div_recip);
    c01         = cmul(h01_q, s_q);
    c10         = cmul(h10_q, s_q);

    unique case (state_q)
      StIdle: begin
        if (hinv.in_valid) begin
          h00_d   = '{re: hinv.h00_re, im: hinv.h00_im};
          h01_d   = '{re: hinv.h01_re, im: hinv.h01_im};
          h10_d   = '{re: hinv.h10_re, im: hinv.h10_im};
          h11_d   = '{re: hinv.h11_re, im: hinv.h11_im};
          state_d = StDet;
        end
      end
      StDet: begin
        det_d.re = sat_sub(p_diag.re, p_anti.re);
        det_d.im = sat_sub(p_diag.im, p_anti.im);
        state_d  = StNorm;
      end
      StNorm: begin
        if (norm == '0) begin
          sing_d  = 1'b1;
          state_d = StAdj;
        end else begin
          sing_d    = 1'b0;
          div_start = 1'b1;
          state_d   = StDiv;
        end
      end
      StDiv: begin
        if (div_done) state_d = StScale;
        else if (!div_busy) state_d = StIdle;  // divider lost its request: drop it
      end
      StScale: begin
        // conj(det) * r
        s_d.re  = sat((widen(det_q.re) * recip_w) >>> FRAC);
        s_d.im  = sat((-widen(det_q.im) * recip_w) >>> FRAC);
        state_d = StAdj;
      end
      StAdj: begin
        out_valid_d = 1'b1;
        singular_d  = sing_q;
        if (sing_q) begin
          i00_d = '0;
          i01_d = '0;
          i10_d = '0;
          i11_d = '0;
        end else begin
          i00_d    = cmul(h11_q, s_q);
          i01_d.re = sat_neg(c01.re);
          i01_d.im = sat_neg(c01.im);
          i10_d.re = sat_neg(c10.re);
          i10_d.im = sat_neg(c10.im);
          i11_d    = cmul(h00_q, s_q);
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      h00_q       <= '0;
      h01_q       <= '0;
      h10_q       <= '0;
      h11_q       <= '0;
      det_q       <= '0;
      s_q         <= '0;
      sing_q      <= 1'b0;
      out_valid_q <= 1'b0;
      singular_q  <= 1'b0;
      i00_q       <= '0;
      i01_q       <= '0;
      i10_q       <= '0;
      i11_q       <= '0;
    end else begin
      state_q     <= state_d;
      h00_q       <= h00_d;
      h01_q       <= h01_d;
      h10_q       <= h10_d;
      h11_q       <= h11_d;
      det_q       <= det_d;
      s_q         <= s_d;
      sing_q      <= sing_d;
      out_valid_q <= out_valid_d;
      singular_q  <= singular_d;
      i00_q       <= i00_d;
      i01_q       <= i01_d;
      i10_q       <= i10_d;
      i11_q       <= i11_d;
    end
  end

  assign hinv.in_ready  = (state_q == StIdle);
  assign hinv.out_valid = out_valid_q;
  assign hinv.singular  = singular_q;
  assign hinv.i00_re    = i00_q.re;
  assign hinv.i00_im    = i00_q.im;
  assign hinv.i01_re    = i01_q.re;
  assign hinv.i01_im    = i01_q.im;
  assign hinv.i10_re    = i10_q.re;
  assign hinv.i10_im    = i10_q.im;
  assign hinv.i11_re    = i11_q.re;
  assign hinv.i11_im    = i11_q.im;

endmodule

// File: tb/tb_mimo_hinv_2x2.sv
// Scoreboard bench for mimo_hinv_2x2: expected inverses from a longint reference model.
module tb_mimo_hinv_2x2;
  import mimo_pkg::*;

  typedef struct packed {
    logic         sing;
    logic [127:0] vals;
    logic [31:0]  acc;
    logic [31:0]  lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  exp_t        exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mimo_hinv_2x2_if bus ();

  mimo_hinv_2x2 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hinv  (bus)
  );

  function automatic logic [127:0] got_vals();
    return {bus.i00_re, bus.i00_im, bus.i01_re, bus.i01_im,
            bus.i10_re, bus.i10_im, bus.i11_re, bus.i11_im};
  endfunction

  function automatic longint sat16(longint x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  function automatic longint cmr(longint ar, longint ai, longint br, longint bi);
    return sat16((ar * br - ai * bi) >>> 11);
  endfunction

  function automatic longint cmi(longint ar, longint ai, longint br, longint bi);
    return sat16((ar * bi + ai * br) >>> 11);
  endfunction

  // h order: h00 re/im, h01 re/im, h10 re/im, h11 re/im
  function automatic exp_t model(input logic signed [15:0] h[8]);
    exp_t   e;
    longint v[8];
    longint dr, di, n, r, sr, si;
    longint o[8];
    for (int i = 0; i < 8; i++) v[i] = longint'(h[i]);
    dr = sat16(cmr(v[0], v[1], v[6], v[7]) - cmr(v[2], v[3], v[4], v[5]));
    di = sat16(cmi(v[0], v[1], v[6], v[7]) - cmi(v[2], v[3], v[4], v[5]));
    n  = dr * dr + di * di;
    e  = '0;
    if (n == 0) begin
      e.sing = 1'b1;
      e.lat  = 3;
    end else begin
      r = (longint'(1) <<< 33) / n;
      if (r > 32767) r = 32767;
      sr   = sat16((dr * r) >>> 11);
      si   = sat16((-di * r) >>> 11);
      o[0] = cmr(v[6], v[7], sr, si);
      o[1] = cmi(v[6], v[7], sr, si);
      o[2] = sat16(-cmr(v[2], v[3], sr, si));
      o[3] = sat16(-cmi(v[2], v[3], sr, si));
      o[4] = sat16(-cmr(v[4], v[5], sr, si));
      o[5] = sat16(-cmi(v[4], v[5], sr, si));
      o[6] = cmr(v[0], v[1], sr, si);
      o[7] = cmi(v[0], v[1], sr, si);
      e.vals = {16'(o[0]), 16'(o[1]), 16'(o[2]), 16'(o[3]),
                16'(o[4]), 16'(o[5]), 16'(o[6]), 16'(o[7])};
      e.lat  = 4 + NUM_W;
    end
    return e;
  endfunction

  task automatic drive_h(input logic signed [15:0] h[8]);
    bus.h00_re = h[0]; bus.h00_im = h[1]; bus.h01_re = h[2]; bus.h01_im = h[3];
    bus.h10_re = h[4]; bus.h10_im = h[5]; bus.h11_re = h[6]; bus.h11_im = h[7];
  endtask

  // Called on a negedge while the DUT is idle; returns on the negedge after the accept edge.
  task automatic send(input logic signed [15:0] h[8]);
    exp_t e;
    e     = model(h);
    e.acc = cyc + 1;
    drive_h(h);
    bus.in_valid = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (bus.out_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Scoreboard consumer
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: out_valid=1 with no request pending, required none");
        end else begin
          e = exp_q.pop_front();
          if (got_vals() !== e.vals) begin
            n_fail++;
            $display("FAIL sb_values: got %h required %h", got_vals(), e.vals);
          end
          n_checks++;
          if (bus.singular !== e.sing) begin
            n_fail++;
            $display("FAIL sb_singular: got %b required %b", bus.singular, e.sing);
          end
          n_checks++;
          if ((cyc - e.acc) !== e.lat) begin
            n_fail++;
            $display("FAIL sb_latency: got %0d required %0d", cyc - e.acc, e.lat);
          end
          n_checks++;
          if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_ready_with_valid: got %b required 1", bus.in_ready);
          end
        end
      end
    end
  end

  task automatic test_reset();
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.singular !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rdy=%b vld=%b sing=%b required 1 0 0",
               bus.in_ready, bus.out_valid, bus.singular);
    end
    n_checks++;
    if (got_vals() !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", got_vals());
    end
  endtask

  task automatic test_identity();
    logic signed [15:0] h[8] = '{2048, 0, 0, 0, 0, 0, 2048, 0};
    bit seen;
    send(h);
    wait_out(seen);
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL identity_timeout: got no out_valid required one"); end
    n_checks++;
    if (bus.i00_re !== 16'sd2048 || bus.i11_re !== 16'sd2048 || bus.singular !== 1'b0) begin
      n_fail++;
      $display("FAIL identity_diag: got %0d %0d sing=%b required 2048 2048 0",
               bus.i00_re, bus.i11_re, bus.singular);
    end
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL identity_pulse_width: got %b required 0", bus.out_valid);
    end
  endtask

  task automatic test_diag2();
    logic signed [15:0] h[8] = '{4096, 0, 0, 0, 0, 0, 4096, 0};
    bit seen;
    send(h);
    wait_out(seen);
    n_checks++;
    if (!seen || bus.i00_re !== 16'sd1024 || bus.i11_re !== 16'sd1024) begin
      n_fail++;
      $display("FAIL diag2_half: got seen=%b %0d %0d required 1 1024 1024",
               seen, bus.i00_re, bus.i11_re);
    end
    @(negedge clk);
  endtask

  task automatic test_imag_diag();
    logic signed [15:0] h[8] = '{0, 2048, 0, 0, 0, 0, 0, 2048};
    bit seen;
    send(h);
    wait_out(seen);
    n_checks++;
    if (!seen || bus.i00_im !== -16'sd2048 || bus.i11_im !== -16'sd2048 ||
        bus.i00_re !== 16'sd0) begin
      n_fail++;
      $display("FAIL imag_diag: got seen=%b %0d %0d %0d required 1 -2048 -2048 0",
               seen, bus.i00_im, bus.i11_im, bus.i00_re);
    end
    @(negedge clk);
  endtask

  task automatic test_singular();
    logic signed [15:0] h[8] = '{1024, 0, 1024, 0, 1024, 0, 1024, 0};
    bit seen;
    send(h);
    wait_out(seen);
    n_checks++;
    if (!seen || bus.singular !== 1'b1 || got_vals() !== 128'h0) begin
      n_fail++;
      $display("FAIL singular_flag: got seen=%b sing=%b vals=%h required 1 1 0",
               seen, bus.singular, got_vals());
    end
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL singular_pulse_width: got %b required 0", bus.out_valid);
    end
  endtask

  // Also covers output hold: 100 idle cycles with the H inputs wiggling.
  task automatic test_clamp_hold();
    logic signed [15:0] h[8] = '{128, 0, 0, 0, 0, 0, 128, 0};
    logic signed [15:0] junk[8];
    exp_t e;
    bit   seen;
    int   extra = 0;
    e = model(h);
    send(h);
    wait_out(seen);
    n_checks++;
    if (!seen || bus.i00_re !== 16'sd7 || bus.i11_re !== 16'sd7) begin
      n_fail++;
      $display("FAIL clamp_recip: got seen=%b %0d %0d required 1 7 7",
               seen, bus.i00_re, bus.i11_re);
    end
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      for (int j = 0; j < 8; j++) junk[j] = 16'($urandom_range(0, 65535));
      drive_h(junk);
      if (bus.out_valid === 1'b1) extra++;
    end
    n_checks++;
    if (extra != 0 || got_vals() !== e.vals || bus.singular !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_100: got extra=%0d vals=%h required 0 %h", extra, got_vals(), e.vals);
    end
  endtask

  task automatic test_busy_ignore();
    logic signed [15:0] a[8] = '{4096, 0, 0, 0, 0, 0, 4096, 0};
    logic signed [15:0] b[8] = '{2048, 0, 0, 0, 0, 0, 2048, 0};
    bit seen;
    int extra = 0;
    send(a);
    repeat (10) @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_ready: got %b required 0", bus.in_ready);
    end
    drive_h(b);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_out(seen);
    n_checks++;
    if (!seen || bus.i00_re !== 16'sd1024) begin
      n_fail++;
      $display("FAIL busy_ignore: got seen=%b i00_re=%0d required 1 1024", seen, bus.i00_re);
    end
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) extra++;
    end
    n_checks++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL busy_no_second: got %0d extra pulses required 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    logic signed [15:0] a[8] = '{0, 2048, 0, 0, 0, 0, 0, 2048};
    logic signed [15:0] b[8] = '{2048, 0, 512, -256, 300, 100, 1024, 700};
    bit seen;
    send(a);
    wait_out(seen);
    n_checks++;
    if (!seen || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready: got seen=%b rdy=%b required 1 1", seen, bus.in_ready);
    end
    send(b);
    wait_out(seen);
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL b2b_timeout: got no out_valid required one"); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic signed [15:0] a[8] = '{4096, 0, 0, 0, 0, 0, 4096, 0};
    int extra = 0;
    send(a);
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || got_vals() !== 128'h0 ||
        bus.singular !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got rdy=%b vld=%b sing=%b vals=%h required 1 0 0 0",
               bus.in_ready, bus.out_valid, bus.singular, got_vals());
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) extra++;
    end
    n_checks++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL reset_mid_late_valid: got %0d pulses required 0", extra);
    end
  endtask

  task automatic test_random();
    logic signed [15:0] h[8];
    bit seen;
    for (int t = 0; t < 8; t++) begin
      for (int j = 0; j < 8; j++) begin
        h[j] = (t < 4) ? 16'($urandom_range(0, 65535))
                       : 16'(int'($urandom_range(0, 8191)) - 4096);
      end
      send(h);
      wait_out(seen);
      n_checks++;
      if (!seen) begin n_fail++; $display("FAIL random_timeout: got no out_valid required one"); end
      @(negedge clk);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.h00_re = '0; bus.h00_im = '0; bus.h01_re = '0; bus.h01_im = '0;
    bus.h10_re = '0; bus.h10_im = '0; bus.h11_re = '0; bus.h11_im = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_identity();
    test_diag2();
    test_imag_diag();
    test_singular();
    test_clamp_hold();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending results required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
